// File: rtl/mem_stall_arbiter.sv
// mem_stall_arbiter: shares one memory refill port between the I-cache and
// the D-cache. It serves one miss at a time, steers the refill beats to the
// owning cache, and freezes the pipeline while any miss is outstanding.
module mem_stall_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imiss,
    input  logic [ADDR_WIDTH-1:0] imiss_addr,
    input  logic                  dmiss,
    input  logic [ADDR_WIDTH-1:0] dmiss_addr,
    input  logic                  abort_i,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  refill_valid,
    output logic                  refill_sel,
    output logic [ADDR_WIDTH-1:0] refill_addr,
    output logic [DATA_WIDTH-1:0] refill_data,
    output logic                  i_done,
    output logic                  d_done,
    output logic                  stall_all
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = CNT_W + 2;
    // Clears the byte offset within a line.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REFILL,
        DONE
    } state_t;

    // side: 0 = I-cache, 1 = D-cache
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    side, side_nxt;
    logic [ADDR_WIDTH-1:0]   line_addr, line_addr_nxt;
    logic                    live;

    // State register with synchronous reset back to an idle, I-side, zero-address state.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            side      <= SIDE_I;
            line_addr <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            side      <= side_nxt;
            line_addr <= line_addr_nxt;
        end
    end

    // Next-state logic: pick a miss (D first), request the line, count beats, pulse done.
    always_comb begin
        // NOTE: hold-value defaults first so no path leaves a signal unassigned (no latches).
        state_nxt     = state;
        cnt_nxt       = cnt;
        side_nxt      = side;
        line_addr_nxt = line_addr;
        case (state)
            IDLE: begin
                // D belongs to the older instruction, so it wins a tie.
                if (dmiss) begin
                    side_nxt      = SIDE_D;
                    line_addr_nxt = dmiss_addr & LINE_MASK;
                    state_nxt     = REQ;
                end else if (imiss) begin
                    side_nxt      = SIDE_I;
                    line_addr_nxt = imiss_addr & LINE_MASK;
                    state_nxt     = REQ;
                end
            end
            REQ: begin
                // An ack in the same cycle as an abort commits the line.
                if (mem_ack) begin
                    cnt_nxt   = '0;
                    state_nxt = REFILL;
                end else if (side == SIDE_I && abort_i) begin
                    state_nxt = IDLE;
                end
            end
            REFILL: begin
                if (mem_valid) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == LAST_BEAT) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the current state; reset silences everything
    // immediately so a late beat or done pulse cannot escape during reset.
    assign live         = !rst;
    assign mem_req      = live && (state == REQ);
    assign mem_addr     = mem_req ? line_addr : '0;
    assign refill_valid = live && (state == REFILL) && mem_valid;
    assign refill_sel   = refill_valid && side;
    assign refill_addr  = refill_valid ? (line_addr + ADDR_WIDTH'({cnt, 2'b00})) : '0;
    assign refill_data  = refill_valid ? mem_rdata : '0;
    assign i_done       = live && (state == DONE) && (side == SIDE_I);
    assign d_done       = live && (state == DONE) && (side == SIDE_D);
    assign stall_all    = (state != IDLE) || imiss || dmiss;

endmodule

// File: tb/tb_mem_stall_arbiter.sv
// Self-checking bench for mem_stall_arbiter: a transaction-level model checks
// every output on every cycle, directed scenarios pin literal values, and a
// randomized phase exercises arbitrary miss/ack/beat/abort/reset patterns.
module tb_mem_stall_arbiter;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imiss;
    logic [31:0] imiss_addr;
    logic        dmiss;
    logic [31:0] dmiss_addr;
    logic        abort_i;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        refill_valid;
    logic        refill_sel;
    logic [31:0] refill_addr;
    logic [31:0] refill_data;
    logic        i_done;
    logic        d_done;
    logic        stall_all;

    mem_stall_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .LINE_WORDS(LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imiss       (imiss),
        .imiss_addr  (imiss_addr),
        .dmiss       (dmiss),
        .dmiss_addr  (dmiss_addr),
        .abort_i     (abort_i),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .refill_valid(refill_valid),
        .refill_sel  (refill_sel),
        .refill_addr (refill_addr),
        .refill_data (refill_data),
        .i_done      (i_done),
        .d_done      (d_done),
        .stall_all   (stall_all)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding line transfer at a time.
    bit          m_active = 1'b0;
    bit          m_acked  = 1'b0;
    int          m_beats  = 0;
    bit          m_side   = 1'b0;
    logic [31:0] m_line   = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit          busy_req, refilling, finishing, e_rv;
            logic [31:0] e_raddr;
            busy_req  = !rst && m_active && !m_acked;
            refilling = m_active && m_acked && (m_beats < LW);
            finishing = m_active && m_acked && (m_beats == LW);
            e_rv      = !rst && refilling && mem_valid;
            e_raddr   = m_line + 32'(4 * m_beats);

            check("mem_req", mem_req, busy_req);
            if (busy_req) check("mem_addr", mem_addr, m_line);
            if (rst || !m_active) begin
                check("mem_addr_idle", mem_addr, 32'h0);
                check("refill_addr_idle", refill_addr, 32'h0);
            end
            check("refill_valid", refill_valid, e_rv);
            if (e_rv) begin
                check("refill_sel", refill_sel, m_side);
                check("refill_addr", refill_addr, e_raddr);
                check("refill_data", refill_data, mem_rdata);
            end
            check("i_done", i_done, !rst && finishing && !m_side);
            check("d_done", d_done, !rst && finishing && m_side);
            check("stall_all", stall_all, m_active || imiss || dmiss);

            // Advance the model with the inputs that the next rising edge will see.
            if (rst) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (dmiss) begin
                    m_active = 1'b1; m_acked = 1'b0; m_side = 1'b1;
                    m_line = dmiss_addr & ~32'(LW * 4 - 1);
                end else if (imiss) begin
                    m_active = 1'b1; m_acked = 1'b0; m_side = 1'b0;
                    m_line = imiss_addr & ~32'(LW * 4 - 1);
                end
            end else if (!m_acked) begin
                if (mem_ack) begin
                    m_acked = 1'b1; m_beats = 0;
                end else if (!m_side && abort_i) begin
                    m_active = 1'b0;
                end
            end else if (m_beats < LW) begin
                if (mem_valid) m_beats++;
            end else begin
                m_active = 1'b0;
            end
        end
    end

    // Observation log for the directed scenarios.
    logic [31:0] beat_addr_q[$];
    bit          beat_sel_q[$];
    int          cyc, i_cnt, d_cnt, req_cnt, i_done_cyc, d_done_cyc, first_lo;
    logic [31:0] last_mem_addr;

    task automatic clear_log();
        beat_addr_q.delete();
        beat_sel_q.delete();
        cyc = 0; i_cnt = 0; d_cnt = 0; req_cnt = 0;
        i_done_cyc = -1; d_done_cyc = -1; first_lo = -1;
        last_mem_addr = '0;
    endtask

    task automatic quiet_inputs();
        imiss = 1'b0; dmiss = 1'b0; abort_i = 1'b0;
        mem_ack = 1'b0; mem_valid = 1'b0;
        imiss_addr = '0; dmiss_addr = '0;
    endtask

    // One cycle: observe at the falling edge, then act like the caches do
    // (drop a miss after its done pulse) just after the rising edge.
    task automatic advance();
        bit saw_i, saw_d;
        @(negedge clk);
        if (refill_valid) begin
            beat_addr_q.push_back(refill_addr);
            beat_sel_q.push_back(refill_sel);
        end
        if (mem_req) begin
            last_mem_addr = mem_addr;
            req_cnt++;
        end
        if (i_done) begin i_done_cyc = cyc; i_cnt++; end
        if (d_done) begin d_done_cyc = cyc; d_cnt++; end
        if (!stall_all && first_lo < 0) first_lo = cyc;
        saw_i = i_done;
        saw_d = d_done;
        @(posedge clk);
        #1;
        if (saw_i) imiss = 1'b0;
        if (saw_d) dmiss = 1'b0;
        mem_rdata = $urandom;
        cyc++;
    endtask

    initial begin
        rst = 1'b1;
        quiet_inputs();
        mem_rdata = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        clear_log();
        advance();
        rst = 1'b0;
        advance();

        // Single D-miss, ack at once, back-to-back beats.
        clear_log();
        dmiss = 1'b1; dmiss_addr = 32'h0001_004C; mem_ack = 1'b1; mem_valid = 1'b1;
        repeat (8) advance();
        check("d1_mem_addr", last_mem_addr, 32'h0001_0040);
        check("d1_beats", beat_addr_q.size(), 4);
        if (beat_addr_q.size() == 4) begin
            check("d1_beat0", beat_addr_q[0], 32'h0001_0040);
            check("d1_beat1", beat_addr_q[1], 32'h0001_0044);
            check("d1_beat2", beat_addr_q[2], 32'h0001_0048);
            check("d1_beat3", beat_addr_q[3], 32'h0001_004C);
            check("d1_sel", {28'h0, beat_sel_q[3], beat_sel_q[2], beat_sel_q[1], beat_sel_q[0]}, 32'hF);
        end
        check("d1_done_cycle", d_done_cyc, 6);
        check("d1_no_idone", i_cnt, 0);
        check("d1_stall_until_idle", first_lo, 7);
        quiet_inputs();
        advance();

        // Simultaneous misses: D first, one idle cycle, then I.
        clear_log();
        imiss = 1'b1; imiss_addr = 32'h2000_0123;
        dmiss = 1'b1; dmiss_addr = 32'h3000_0ABC;
        mem_ack = 1'b1; mem_valid = 1'b1;
        repeat (16) advance();
        check("both_d_done", d_done_cyc, 6);
        check("both_i_done", i_done_cyc, 13);
        check("both_counts", {i_cnt[15:0], d_cnt[15:0]}, {16'd1, 16'd1});
        check("both_beats", beat_addr_q.size(), 8);
        if (beat_addr_q.size() == 8) begin
            check("both_first_d", beat_addr_q[0], 32'h3000_0AB0);
            check("both_first_i", beat_addr_q[4], 32'h2000_0120);
            check("both_sel_order", {31'h0, beat_sel_q[3] & !beat_sel_q[4]}, 32'h1);
        end
        quiet_inputs();
        advance();

        // Abort without ack: request withdrawn, no done pulse.
        clear_log();
        imiss = 1'b1; imiss_addr = 32'h0000_0044;
        advance();
        abort_i = 1'b1;
        advance();
        abort_i = 1'b0; imiss = 1'b0;
        repeat (4) advance();
        check("abort_req_cycles", req_cnt, 1);
        check("abort_no_idone", i_cnt, 0);

        // Abort together with ack: line completes.
        clear_log();
        imiss = 1'b1; imiss_addr = 32'h0000_0080;
        advance();
        abort_i = 1'b1; mem_ack = 1'b1;
        advance();
        abort_i = 1'b0; mem_ack = 1'b0; mem_valid = 1'b1;
        repeat (7) advance();
        check("abort_ack_idone", i_done_cyc, 6);
        check("abort_ack_beats", beat_addr_q.size(), 4);
        quiet_inputs();
        advance();

        // Gapped refill: beats on alternate cycles.
        clear_log();
        dmiss = 1'b1; dmiss_addr = 32'h0000_0500; mem_ack = 1'b1;
        repeat (12) begin
            mem_valid = (cyc % 2 == 0);
            advance();
        end
        check("gap_done_cycle", d_done_cyc, 9);
        check("gap_beats", beat_addr_q.size(), 4);
        if (beat_addr_q.size() == 4) check("gap_last_addr", beat_addr_q[3], 32'h0000_050C);
        quiet_inputs();
        advance();

        // Reset after two beats, then a fresh miss restarts from beat 0.
        clear_log();
        dmiss = 1'b1; dmiss_addr = 32'h0000_0700; mem_ack = 1'b1; mem_valid = 1'b1;
        repeat (4) advance();
        rst = 1'b1; dmiss = 1'b0;
        advance();
        rst = 1'b0;
        repeat (3) advance();
        check("rst_beats_kept", beat_addr_q.size(), 2);
        check("rst_no_done", d_cnt, 0);
        clear_log();
        dmiss = 1'b1; dmiss_addr = 32'h0000_0904;
        repeat (8) advance();
        check("rst_restart_beats", beat_addr_q.size(), 4);
        if (beat_addr_q.size() == 4) check("rst_restart_first", beat_addr_q[0], 32'h0000_0900);
        check("rst_restart_done", d_done_cyc, 6);
        quiet_inputs();
        advance();

        // Randomized traffic; the model checks every cycle.
        repeat (4000) begin
            if (!imiss && $urandom_range(7) == 0) begin imiss = 1'b1; imiss_addr = $urandom; end
            else if (imiss && $urandom_range(3) == 0) imiss_addr = $urandom;
            if (!dmiss && $urandom_range(7) == 0) begin dmiss = 1'b1; dmiss_addr = $urandom; end
            else if (dmiss && $urandom_range(3) == 0) dmiss_addr = $urandom;
            mem_ack   = ($urandom_range(2) == 0);
            mem_valid = $urandom_range(1) == 1;
            abort_i   = ($urandom_range(5) == 0);
            rst       = ($urandom_range(199) == 0);
            if (rst && $urandom_range(1) == 1) begin imiss = 1'b0; dmiss = 1'b0; end
            advance();
        end
        rst = 1'b0;
        quiet_inputs();
        repeat (12) advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
